// File: rtl/peripheral_ahb4_pkg.sv
// rtl/peripheral_ahb4_pkg.sv - shared AHB4-Lite encodings and the request bundle used by the arbiter
package peripheral_ahb4_pkg;

  // Widest address the request bundle can carry; narrower buses zero-extend into it.
  localparam int AHB_ADDR_MAX = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef struct packed {
    logic                    sel;
    logic [AHB_ADDR_MAX-1:0] addr;
    logic                    write;
    logic [2:0]              size;
    logic [2:0]              burst;
    logic [3:0]              prot;
    logic [1:0]              trans;
    logic                    lock;
  } ahb_req_t;

  function automatic logic req_active(input ahb_req_t r);
    return r.sel && ((r.trans == HTRANS_NONSEQ) || (r.trans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// rtl/peripheral_arbiter_rr.sv - round-robin grant with hold; decision is combinational, grant and last index registered
module peripheral_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic          i_hold,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_last
);

  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_last;
  logic [N-1:0]  w_pick;
  logic [IW-1:0] w_pick_idx;
  logic          w_arb;

  // Scan from farthest to nearest so the first requester after r_last wins.
  always_comb begin
    w_pick     = '0;
    w_pick_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(r_last) + k) % N]) begin
        w_pick                            = '0;
        w_pick[(int'(r_last) + k) % N]    = 1'b1;
        w_pick_idx                        = IW'((int'(r_last) + k) % N);
      end
    end
  end

  assign w_arb  = i_en && !(i_hold && (|r_gnt));
  assign o_gnt  = w_arb ? w_pick : r_gnt;
  assign o_last = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= '0;
      r_last <= IW'(N - 1);
    end else if (w_arb) begin
      r_gnt <= w_pick;
      if (|i_req) r_last <= w_pick_idx;
    end
  end

endmodule

// File: rtl/peripheral_arbiter_ahb4.sv
// rtl/peripheral_arbiter_ahb4.sv - N:1 AHB4-Lite arbiter with per-master address capture in front of one shared slave
module peripheral_arbiter_ahb4 #(
  parameter int MASTERS    = 2,
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [MASTERS-1:0]                 mst_HSEL,
  input  logic [MASTERS-1:0][HADDR_SIZE-1:0] mst_HADDR,
  input  logic [MASTERS-1:0][HDATA_SIZE-1:0] mst_HWDATA,
  input  logic [MASTERS-1:0]                 mst_HWRITE,
  input  logic [MASTERS-1:0][2:0]            mst_HSIZE,
  input  logic [MASTERS-1:0][2:0]            mst_HBURST,
  input  logic [MASTERS-1:0][3:0]            mst_HPROT,
  input  logic [MASTERS-1:0][1:0]            mst_HTRANS,
  input  logic [MASTERS-1:0]                 mst_HMASTLOCK,
  output logic [MASTERS-1:0][HDATA_SIZE-1:0] mst_HRDATA,
  output logic [MASTERS-1:0]                 mst_HREADYOUT,
  output logic [MASTERS-1:0]                 mst_HRESP,
  output logic                               slv_HSEL,
  output logic [HADDR_SIZE-1:0]              slv_HADDR,
  output logic [HDATA_SIZE-1:0]              slv_HWDATA,
  output logic                               slv_HWRITE,
  output logic [2:0]                         slv_HSIZE,
  output logic [2:0]                         slv_HBURST,
  output logic [3:0]                         slv_HPROT,
  output logic [1:0]                         slv_HTRANS,
  output logic                               slv_HMASTLOCK,
  output logic                               slv_HREADY,
  input  logic [HDATA_SIZE-1:0]              slv_HRDATA,
  input  logic                               slv_HREADYOUT,
  input  logic                               slv_HRESP,
  output logic [MASTERS-1:0]                 gnt
);
  import peripheral_ahb4_pkg::*;

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  ahb_req_t           w_live [MASTERS];
  ahb_req_t           w_eff  [MASTERS];
  ahb_req_t           r_cap  [MASTERS];
  ahb_req_t           w_fwd;
  logic [MASTERS-1:0] r_pend;
  logic [MASTERS-1:0] w_req;
  logic [MASTERS-1:0] w_gnt;
  logic [MASTERS-1:0] w_own;
  logic [MASTERS-1:0] w_rdy;
  logic [MASTERS-1:0] w_resp;
  logic [MASTERS-1:0] w_take;
  logic [IW-1:0]      w_last;
  logic [IW-1:0]      w_gnt_idx;
  logic [IW-1:0]      r_owner;
  logic               r_owner_vld;
  logic               w_hold;
  logic               w_unused_addr;

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_live[m]                      = '0;
      w_live[m].sel                  = mst_HSEL[m];
      w_live[m].addr[HADDR_SIZE-1:0] = mst_HADDR[m];
      w_live[m].write                = mst_HWRITE[m];
      w_live[m].size                 = mst_HSIZE[m];
      w_live[m].burst                = mst_HBURST[m];
      w_live[m].prot                 = mst_HPROT[m];
      w_live[m].trans                = mst_HTRANS[m];
      w_live[m].lock                 = mst_HMASTLOCK[m];
      w_eff[m]                       = r_pend[m] ? r_cap[m] : w_live[m];
      w_req[m]                       = req_active(w_eff[m]);
    end
  end

  // Bursts keep the bus through SEQ/BUSY; a lock keeps it only while the owner issues locked NONSEQs.
  always_comb begin
    w_hold = w_eff[w_last].sel &&
             ((w_eff[w_last].trans == HTRANS_SEQ) ||
              (w_eff[w_last].trans == HTRANS_BUSY) ||
              (w_eff[w_last].lock && (w_eff[w_last].trans == HTRANS_NONSEQ)));
  end

  peripheral_arbiter_rr #(
    .N  (MASTERS),
    .IW (IW)
  ) u_rr (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .i_req  (w_req),
    .i_en   (slv_HREADYOUT),
    .i_hold (w_hold),
    .o_gnt  (w_gnt),
    .o_last (w_last)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (w_gnt[m]) w_gnt_idx = IW'(m);
    end
    w_fwd = '0;
    if (|w_gnt) w_fwd = w_eff[w_gnt_idx];
  end

  // A master that sees ready but is not taken by the slave this cycle gets parked in r_cap.
  always_comb begin
    w_own  = '0;
    w_rdy  = '0;
    w_resp = '0;
    w_take = '0;
    for (int m = 0; m < MASTERS; m++) begin
      w_own[m]  = r_owner_vld && (r_owner == IW'(m));
      w_rdy[m]  = r_pend[m] ? 1'b0 : (w_own[m] ? slv_HREADYOUT : 1'b1);
      w_resp[m] = w_own[m] && slv_HRESP;
      w_take[m] = w_rdy[m] && req_active(w_live[m]) && !(w_gnt[m] && slv_HREADYOUT);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend      <= '0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      for (int m = 0; m < MASTERS; m++) r_cap[m] <= '0;
    end else begin
      for (int m = 0; m < MASTERS; m++) begin
        if (w_take[m]) begin
          r_pend[m] <= 1'b1;
          r_cap[m]  <= w_live[m];
        end else if (w_gnt[m] && slv_HREADYOUT) begin
          r_pend[m] <= 1'b0;
        end
      end
      if (slv_HREADYOUT) begin
        r_owner_vld <= (|w_gnt) && req_active(w_fwd);
        r_owner     <= w_gnt_idx;
      end
    end
  end

  assign slv_HSEL      = w_fwd.sel;
  assign slv_HADDR     = w_fwd.addr[HADDR_SIZE-1:0];
  assign slv_HWRITE    = w_fwd.write;
  assign slv_HSIZE     = w_fwd.size;
  assign slv_HBURST    = w_fwd.burst;
  assign slv_HPROT     = w_fwd.prot;
  assign slv_HTRANS    = w_fwd.trans;
  assign slv_HMASTLOCK = w_fwd.lock;
  assign slv_HWDATA    = mst_HWDATA[r_owner];
  assign slv_HREADY    = slv_HREADYOUT;
  assign mst_HRDATA    = {MASTERS{slv_HRDATA}};
  assign mst_HREADYOUT = w_rdy;
  assign mst_HRESP     = w_resp;
  assign gnt           = w_gnt;
  assign w_unused_addr = ^w_fwd.addr;

endmodule

// File: tb/tb_peripheral_arbiter_ahb4.sv
// tb/tb_peripheral_arbiter_ahb4.sv - directed bench for peripheral_arbiter_ahb4 with a small memory slave
module tb_peripheral_arbiter_ahb4;
  import peripheral_ahb4_pkg::*;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic [1:0]       mst_HSEL, mst_HWRITE, mst_HMASTLOCK;
  logic [1:0][15:0] mst_HADDR;
  logic [1:0][31:0] mst_HWDATA;
  logic [1:0][2:0]  mst_HSIZE, mst_HBURST;
  logic [1:0][3:0]  mst_HPROT;
  logic [1:0][1:0]  mst_HTRANS;
  logic [1:0][31:0] mst_HRDATA;
  logic [1:0]       mst_HREADYOUT, mst_HRESP;
  logic             slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADY;
  logic [15:0]      slv_HADDR;
  logic [31:0]      slv_HWDATA;
  logic [2:0]       slv_HSIZE, slv_HBURST;
  logic [3:0]       slv_HPROT;
  logic [1:0]       slv_HTRANS;
  logic [1:0]       gnt;
  logic             s_ready = 1'b1;
  logic             s_resp = 1'b0;
  logic [31:0]      s_rdata;

  logic [31:0] mem [16];
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [3:0]  dp_idx = 4'd0;
  logic [1:0]  lg_gnt [$];
  logic [1:0]  lg_tr [$];
  logic [15:0] lg_addr [$];

  int checks = 0;
  int errors = 0;

  peripheral_arbiter_ahb4 #(.MASTERS(2), .HADDR_SIZE(16), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR), .mst_HWDATA(mst_HWDATA),
    .mst_HWRITE(mst_HWRITE), .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST),
    .mst_HPROT(mst_HPROT), .mst_HTRANS(mst_HTRANS), .mst_HMASTLOCK(mst_HMASTLOCK),
    .mst_HRDATA(mst_HRDATA), .mst_HREADYOUT(mst_HREADYOUT), .mst_HRESP(mst_HRESP),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
    .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
    .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
    .slv_HREADY(slv_HREADY), .slv_HRDATA(s_rdata), .slv_HREADYOUT(s_ready),
    .slv_HRESP(s_resp), .gnt(gnt)
  );

  always #5 HCLK = ~HCLK;

  assign s_rdata = mem[dp_idx];

  always @(posedge HCLK) begin
    if (slv_HREADY) begin
      if (dp_valid && dp_write) mem[dp_idx] <= slv_HWDATA;
      dp_valid <= slv_HSEL && slv_HTRANS[1];
      dp_idx   <= slv_HADDR[5:2];
      dp_write <= slv_HWRITE;
      if (slv_HSEL && slv_HTRANS[1]) begin
        lg_gnt.push_back(gnt);
        lg_tr.push_back(slv_HTRANS);
        lg_addr.push_back(slv_HADDR);
      end
    end
  end

  task automatic drv(input int m, input logic [1:0] tr, input logic [15:0] a,
                     input logic w, input logic [2:0] b, input logic lk);
    mst_HSEL[m]      = (tr != HTRANS_IDLE);
    mst_HTRANS[m]    = tr;
    mst_HADDR[m]     = a;
    mst_HWRITE[m]    = w;
    mst_HBURST[m]    = b;
    mst_HMASTLOCK[m] = lk;
    mst_HSIZE[m]     = 3'd2;
    mst_HPROT[m]     = 4'h3;
  endtask

  task automatic idle(input int m);
    drv(m, HTRANS_IDLE, 16'h0000, 1'b0, HBURST_SINGLE, 1'b0);
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic clear_log;
    lg_gnt.delete();
    lg_tr.delete();
    lg_addr.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mst_HWDATA = '0;
    idle(0);
    idle(1);
    #2;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_htrans", slv_HTRANS, HTRANS_IDLE);
    chk("rst_hsel", slv_HSEL, 1'b0);
    chk("rst_lock", slv_HMASTLOCK, 1'b0);
    chk("rst_readyout", mst_HREADYOUT, 2'b11);
    chk("rst_resp", mst_HRESP, 2'b00);
    tick();
    tick();
    HRESETn = 1'b1;

    // Collision: M0 and M1 NONSEQ together
    tick();
    drv(0, HTRANS_NONSEQ, 16'h0010, 1'b1, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 16'h0020, 1'b1, HBURST_SINGLE, 1'b0);
    #2;
    chk("col_gnt0", gnt, 2'b01);
    chk("col_addr0", slv_HADDR, 16'h0010);
    chk("col_trans0", slv_HTRANS, HTRANS_NONSEQ);
    chk("col_rdy0", mst_HREADYOUT, 2'b11);
    tick();
    idle(0);
    idle(1);
    mst_HWDATA[0] = 32'h0000_0011;
    mst_HWDATA[1] = 32'h0000_0022;
    #2;
    chk("col_gnt1", gnt, 2'b10);
    chk("col_addr1", slv_HADDR, 16'h0020);
    chk("col_rdy1", mst_HREADYOUT, 2'b01);
    chk("col_wdata0", slv_HWDATA, 32'h0000_0011);
    tick();
    #2;
    chk("col_gnt2", gnt, 2'b00);
    chk("col_trans2", slv_HTRANS, HTRANS_IDLE);
    chk("col_rdy2", mst_HREADYOUT, 2'b11);
    chk("col_wdata1", slv_HWDATA, 32'h0000_0022);
    chk("col_log_n", lg_gnt.size(), 2);
    chk("col_log_g0", lg_gnt[0], 2'b01);
    chk("col_log_g1", lg_gnt[1], 2'b10);
    clear_log();

    // Single master write then read back
    tick();
    drv(0, HTRANS_NONSEQ, 16'h0004, 1'b1, HBURST_SINGLE, 1'b0);
    #2;
    chk("sm_gnt", gnt, 2'b01);
    tick();
    drv(0, HTRANS_NONSEQ, 16'h0004, 1'b0, HBURST_SINGLE, 1'b0);
    mst_HWDATA[0] = 32'h0000_00A5;
    #2;
    chk("sm_wdata", slv_HWDATA, 32'h0000_00A5);
    chk("sm_rdy", mst_HREADYOUT, 2'b11);
    chk("sm_hwrite", slv_HWRITE, 1'b0);
    tick();
    idle(0);
    #2;
    chk("sm_rdata0", mst_HRDATA[0], 32'h0000_00A5);
    chk("sm_rdata1", mst_HRDATA[1], 32'h0000_00A5);
    chk("sm_log_n", lg_tr.size(), 2);
    chk("sm_log_t0", lg_tr[0], HTRANS_NONSEQ);
    chk("sm_log_t1", lg_tr[1], HTRANS_NONSEQ);
    clear_log();

    // Burst hold: M0 INCR4 with a BUSY, M1 requesting meanwhile
    tick();
    drv(0, HTRANS_NONSEQ, 16'h0040, 1'b1, HBURST_INCR4, 1'b0);
    #2;
    chk("bu_gnt0", gnt, 2'b01);
    tick();
    drv(0, HTRANS_SEQ, 16'h0044, 1'b1, HBURST_INCR4, 1'b0);
    drv(1, HTRANS_NONSEQ, 16'h0080, 1'b1, HBURST_SINGLE, 1'b0);
    #2;
    chk("bu_gnt1", gnt, 2'b01);
    chk("bu_addr1", slv_HADDR, 16'h0044);
    chk("bu_rdy1", mst_HREADYOUT, 2'b11);
    tick();
    drv(0, HTRANS_BUSY, 16'h0048, 1'b1, HBURST_INCR4, 1'b0);
    idle(1);
    #2;
    chk("bu_gnt_busy", gnt, 2'b01);
    chk("bu_trans_busy", slv_HTRANS, HTRANS_BUSY);
    chk("bu_rdy_busy", mst_HREADYOUT, 2'b01);
    tick();
    drv(0, HTRANS_SEQ, 16'h0048, 1'b1, HBURST_INCR4, 1'b0);
    #2;
    chk("bu_gnt3", gnt, 2'b01);
    tick();
    drv(0, HTRANS_SEQ, 16'h004C, 1'b1, HBURST_INCR4, 1'b0);
    #2;
    chk("bu_gnt4", gnt, 2'b01);
    chk("bu_m1_stall", mst_HREADYOUT[1], 1'b0);
    tick();
    idle(0);
    #2;
    chk("bu_gnt_m1", gnt, 2'b10);
    chk("bu_addr_m1", slv_HADDR, 16'h0080);
    tick();
    #2;
    chk("bu_rdy_end", mst_HREADYOUT, 2'b11);
    chk("bu_log_n", lg_gnt.size(), 5);
    chk("bu_log_g0", lg_gnt[0], 2'b01);
    chk("bu_log_t1", lg_tr[1], HTRANS_SEQ);
    chk("bu_log_a2", lg_addr[2], 16'h0048);
    chk("bu_log_t3", lg_tr[3], HTRANS_SEQ);
    chk("bu_log_g3", lg_gnt[3], 2'b01);
    chk("bu_log_g4", lg_gnt[4], 2'b10);
    clear_log();

    // Locked read-modify-write by M1 while M0 requests
    tick();
    drv(1, HTRANS_NONSEQ, 16'h0008, 1'b0, HBURST_SINGLE, 1'b1);
    #2;
    chk("lk_gnt0", gnt, 2'b10);
    chk("lk_lock0", slv_HMASTLOCK, 1'b1);
    tick();
    drv(1, HTRANS_NONSEQ, 16'h0008, 1'b1, HBURST_SINGLE, 1'b1);
    drv(0, HTRANS_NONSEQ, 16'h0030, 1'b1, HBURST_SINGLE, 1'b0);
    #2;
    chk("lk_gnt_held", gnt, 2'b10);
    chk("lk_hwrite", slv_HWRITE, 1'b1);
    chk("lk_rdy1", mst_HREADYOUT, 2'b11);
    tick();
    idle(0);
    idle(1);
    mst_HWDATA[1] = 32'h0000_005A;
    #2;
    chk("lk_gnt_m0", gnt, 2'b01);
    chk("lk_lock_off", slv_HMASTLOCK, 1'b0);
    chk("lk_rdy2", mst_HREADYOUT, 2'b10);
    chk("lk_wdata", slv_HWDATA, 32'h0000_005A);
    tick();
    #2;
    chk("lk_rdy3", mst_HREADYOUT, 2'b11);
    chk("lk_log_n", lg_gnt.size(), 3);
    chk("lk_log_g1", lg_gnt[1], 2'b10);
    chk("lk_log_g2", lg_gnt[2], 2'b01);
    clear_log();

    // Two wait states then a two-cycle ERROR on M0, M1 captured meanwhile
    tick();
    drv(0, HTRANS_NONSEQ, 16'h000C, 1'b0, HBURST_SINGLE, 1'b0);
    #2;
    chk("er_gnt0", gnt, 2'b01);
    tick();
    idle(0);
    drv(1, HTRANS_NONSEQ, 16'h0050, 1'b1, HBURST_SINGLE, 1'b0);
    s_ready = 1'b0;
    #2;
    chk("er_rdy_w1", mst_HREADYOUT, 2'b10);
    tick();
    idle(1);
    #2;
    chk("er_rdy_w2", mst_HREADYOUT, 2'b00);
    chk("er_resp_w2", mst_HRESP, 2'b00);
    tick();
    s_resp = 1'b1;
    #2;
    chk("er_rdy_e1", mst_HREADYOUT, 2'b00);
    chk("er_resp_e1", mst_HRESP, 2'b01);
    tick();
    s_ready = 1'b1;
    #2;
    chk("er_rdy_e2", mst_HREADYOUT, 2'b01);
    chk("er_resp_e2", mst_HRESP, 2'b01);
    chk("er_gnt_m1", gnt, 2'b10);
    chk("er_addr_m1", slv_HADDR, 16'h0050);
    tick();
    s_resp = 1'b0;
    #2;
    chk("er_rdy_end", mst_HREADYOUT, 2'b11);
    chk("er_resp_end", mst_HRESP, 2'b00);

    // Reset while M1 holds a captured transfer
    tick();
    drv(0, HTRANS_NONSEQ, 16'h0060, 1'b1, HBURST_SINGLE, 1'b0);
    drv(1, HTRANS_NONSEQ, 16'h0070, 1'b1, HBURST_SINGLE, 1'b0);
    #2;
    chk("rs_gnt0", gnt, 2'b01);
    tick();
    idle(0);
    idle(1);
    #1;
    chk("rs_pend_seen", mst_HREADYOUT, 2'b01);
    HRESETn = 1'b0;
    #1;
    chk("rs_gnt", gnt, 2'b00);
    chk("rs_trans", slv_HTRANS, HTRANS_IDLE);
    chk("rs_hsel", slv_HSEL, 1'b0);
    chk("rs_rdy", mst_HREADYOUT, 2'b11);
    tick();
    HRESETn = 1'b1;
    #2;
    chk("rs_gnt_after", gnt, 2'b00);
    chk("rs_trans_after", slv_HTRANS, HTRANS_IDLE);
    tick();
    drv(1, HTRANS_NONSEQ, 16'h0070, 1'b1, HBURST_SINGLE, 1'b0);
    #2;
    chk("rs_reissue_gnt", gnt, 2'b10);
    chk("rs_reissue_addr", slv_HADDR, 16'h0070);
    tick();
    idle(1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_arbiter_ahb4.md
Name: peripheral_arbiter_ahb4

Overview:
AHB4-Lite N:1 arbiter that shares one AHB-Lite slave, e.g. peripheral_timer_ahb4, between MASTERS bus masters (BFMs, DMA engines, CPU ports).
- Each master port has an input stage that captures an address phase the slave cannot take yet, then stalls that master's data phase.
- Grant is round-robin per transfer.
- Grant is held across bursts and locked sequences.
- Sits between masters and the slave. slv_HREADY loops back as the slave's HREADY.

Parameters:
- MASTERS, 2, number of requesting masters (2..8).
- HADDR_SIZE, 16, address width.
- HDATA_SIZE, 32, data width.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- mst_HSEL  in  [MASTERS]  per-master select.
- mst_HADDR  in  [MASTERS][HADDR_SIZE]  address.
- mst_HWDATA  in  [MASTERS][HDATA_SIZE]  write data.
- mst_HWRITE  in  [MASTERS]  write.
- mst_HSIZE/mst_HBURST  in  [MASTERS][3]  size/burst.
- mst_HPROT  in  [MASTERS][4]  protection.
- mst_HTRANS  in  [MASTERS][2]  transfer type.
- mst_HMASTLOCK  in  [MASTERS]  lock.
- mst_HRDATA  out  [MASTERS][HDATA_SIZE]  read data (broadcast of slv_HRDATA).
- mst_HREADYOUT  out  [MASTERS]  per-master ready.
- mst_HRESP  out  [MASTERS]  per-master response.
- slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK  out  widths as above  muxed slave request.
- slv_HREADY  out  1  equals slv_HREADYOUT.
- slv_HRDATA  in  HDATA_SIZE  slave read data.
- slv_HREADYOUT  in  1  slave ready.
- slv_HRESP  in  1  slave response.
- gnt  out  [MASTERS]  one-hot address-phase grant (debug/coverage).

Behaviour:
- Reset state: pend=0, gnt=0, data owner invalid, slv_HTRANS=IDLE, slv_HSEL=0, slv_HMASTLOCK=0, all mst_HREADYOUT=1, mst_HRESP=0.
- Effective request of master m: the captured register when pend[m]=1, otherwise the live inputs.
- Master m requests when its effective request has HSEL=1 and HTRANS is NONSEQ or SEQ.
- Live address phase acceptance: a live phase is accepted only in a cycle where mst_HREADYOUT[m]=1.
  - If accepted and not forwarded to the slave that cycle, capture addr/ctrl and set pend[m].
  - pend[m] clears in the cycle it is forwarded with slv_HREADYOUT=1.
- Arbitration point: slv_HREADYOUT=1 and grant not held.
  - Grant is held while the granted master's effective request is SEQ or BUSY, or has HMASTLOCK=1.
  - Lock is released on the first unlocked transfer or IDLE.
  - Next grant is the first requester after the last granted index, cyclically. No requester gives gnt=0 and slv_HTRANS=IDLE.
  - Grant changes only on an arbitration point. 0-cycle decision; the forwarded address appears combinationally.
- Data owner: registered index of the master whose address phase the slave accepted. Updated when slv_HREADYOUT=1; invalid after IDLE.
  - slv_HWDATA = mst_HWDATA[owner].
- mst_HREADYOUT[m]:
  - pend[m]=1 → 0.
  - owner==m → slv_HREADYOUT.
  - otherwise → 1.
- mst_HRESP[m]: slv_HRESP when owner==m, else 0. The two-cycle ERROR is passed through unchanged. A transfer already captured after an ERROR is still issued.
- Simultaneous events: a master requesting while it owns the data phase wins no priority; it is re-arbitrated normally.
- Reset mid-transfer: all state is cleared asynchronously. A pending capture is dropped.
- Width rules: index width is $clog2(MASTERS), minimum 1. Round-robin wraps from MASTERS-1 to 0.

Decomposition:
- Shared package peripheral_ahb4_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HBURST_SINGLE..INCR16 constants.
  - Packed struct ahb_req_t {sel, addr, write, size, burst, prot, trans, lock}, used for the capture registers and the mux.
- Sub-module peripheral_arbiter_rr: request vector, enable and hold in; one-hot grant and last-index register out.

Test Plan:
- Single master: M0 write 0x0000_00A5 to 0x0004, then read → slave sees one NONSEQ per transfer, M1 never stalls, read returns 0xA5.
- Collision: M0 and M1 issue NONSEQ SINGLE in the same cycle → M0 forwarded first, M1 captured with mst_HREADYOUT[1]=0 for 1 cycle, M1 forwarded next. gnt sequence 01, 10.
- Burst hold: M0 INCR4 while M1 requests → slave sees 4 consecutive M0 beats (NONSEQ+3×SEQ) before M1; BUSY in the burst keeps the grant.
- Lock: M1 locked read-modify-write to 0x0008 with M0 requesting → M0 is not granted until M1 drops HMASTLOCK.
- Wait states/error: slave inserts 2 wait states, then ERROR on an M0 access → only M0 sees HREADYOUT low 3 cycles and HRESP=1 over two cycles; M1's captured transfer proceeds afterwards.
- Reset: assert HRESETn low while pend[1]=1 → pend clears, gnt=0, slv_HTRANS=IDLE immediately; after release M1 must reissue.
